// File: rtl/epoch_load_ctrl_if.sv
// Byte/time bundle between the timestamp source, the loader and the clock core.
// Plain wires, no storage; the slave side is the loader.
interface epoch_load_ctrl_if;
    logic [7:0]         byte_in;
    logic               byte_valid;
    logic signed [17:0] tz_offset;
    logic               tick_1hz;
    logic [27:0]        t_out;
    logic               t_load;
    logic               busy;
    logic               err;
    logic [1:0]         err_code;

    modport master (
        output byte_in, byte_valid, tz_offset, tick_1hz,
        input  t_out, t_load, busy, err, err_code
    );

    modport slave (
        input  byte_in, byte_valid, tz_offset, tick_1hz,
        output t_out, t_load, busy, err, err_code
    );
endinterface

// File: rtl/epoch_load_ctrl.sv
// Serial Unix timestamp -> 2020-epoch local seconds, range-checked, one-cycle load pulse.
// Latency: 4th byte in cycle N gives t_load in cycle N+3; bytes arriving in CHECK/APPLY/LOAD are dropped.
module epoch_load_ctrl #(
    parameter logic [31:0] EPOCH          = 32'd1577836800,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
    input logic               clk,
    input logic               rst_n,
    epoch_load_ctrl_if.slave  bus
);
    localparam int unsigned          TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]      TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_CHECK, S_APPLY, S_LOAD, S_ERROR
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     shift_q, shift_d;
    logic [31:0]     diff_q, diff_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      tick_q, tick_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [27:0]     t_out_q, t_out_d;
    logic [1:0]      code_q, code_d;

    logic [3:0]      tick_inc;
    logic [33:0]     sum;
    logic            sum_bad;

    assign tick_inc = (bus.tick_1hz && (tick_q != 4'hF)) ? tick_q + 4'd1 : tick_q;

    // All operands fit well inside 34 bits, so bit 33 is the sign of the true sum.
    assign sum     = {2'b00, diff_q} + {{16{bus.tz_offset[17]}}, bus.tz_offset} + {30'd0, tick_inc};
    assign sum_bad = sum[33] || (|sum[32:28]);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        tick_d  = tick_q;
        to_d    = to_q;
        t_out_d = t_out_q;
        code_d  = code_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (bus.byte_valid) begin
                    shift_d = {24'd0, bus.byte_in};
                    cnt_d   = 3'd1;
                    tick_d  = {3'd0, bus.tick_1hz};
                    to_d    = '0;
                    code_d  = 2'b00;
                    state_d = S_COLLECT;
                end
            end
            S_COLLECT: begin
                tick_d = tick_inc;
                if (bus.byte_valid) begin
                    shift_d = {shift_q[23:0], bus.byte_in};
                    cnt_d   = cnt_q + 3'd1;
                    to_d    = '0;
                    if (cnt_q == 3'd3) state_d = S_CHECK;
                end else if (to_q == TO_LAST) begin
                    code_d  = 2'b11;
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_CHECK: begin
                tick_d = tick_inc;
                if (shift_q < EPOCH) begin
                    code_d  = 2'b01;
                    state_d = S_ERROR;
                end else begin
                    diff_d  = shift_q - EPOCH;
                    state_d = S_APPLY;
                end
            end
            S_APPLY: begin
                if (sum_bad) begin
                    code_d  = 2'b10;
                    state_d = S_ERROR;
                end else begin
                    t_out_d = sum[27:0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            tick_q  <= '0;
            to_q    <= '0;
            t_out_q <= '0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            to_q    <= to_d;
            t_out_q <= t_out_d;
            code_q  <= code_d;
        end
    end

    assign bus.t_out    = t_out_q;
    assign bus.t_load   = (state_q == S_LOAD);
    assign bus.busy     = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign bus.err      = (state_q == S_ERROR);
    assign bus.err_code = code_q;
endmodule
